// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver: FSM states,
// parity mode encodings, the default idle line level and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_PARITY_BIT = 3'd3,
        ST_STOP       = 3'd4
    } uart_tx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam logic UART_IDLE_LEVEL = 1'b0;

    // Unused upper bits are zero, so they never disturb the XOR.
    function automatic logic parity_of(input logic [7:0] word, input int mode);
        return (mode == PARITY_ODD) ? ~(^word) : ^word;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts clocks while enabled and flags the last clock of
// each serial bit. Held at zero while disabled so every frame starts aligned.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic bit_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign bit_done = enable && (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts one word per valid/ready handshake and sends
// start bit, data LSB first, optional parity and stop bit(s) on a registered line.
module uart_tx
    import uart_pkg::*;
#(
    parameter int   CLKS_PER_BIT = 1,
    parameter int   DATA_BITS    = 8,
    parameter int   PARITY       = PARITY_NONE,
    parameter int   STOP_BITS    = 1,
    parameter logic IDLE_LEVEL   = UART_IDLE_LEVEL
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 data_valid,
    output logic                 ready,
    output logic                 signal,
    output logic                 busy,
    output uart_tx_state_t       state
);

    // Handshake: a word transfers on any rising edge where data_valid and
    // ready are both high; ready is high only in IDLE and inputs are ignored
    // otherwise.

    if (CLKS_PER_BIT < 1) begin : g_bad_clks
        $error("uart_tx: CLKS_PER_BIT must be at least 1");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
        $error("uart_tx: DATA_BITS must be 5..8");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    logic [DATA_BITS-1:0] shreg;
    logic [BW-1:0]        bit_cnt;
    logic                 stop_cnt;
    logic                 par_bit;
    logic                 bit_done;

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .enable  (state != ST_IDLE),
        .bit_done(bit_done)
    );

    // signal is loaded with the level of the state being entered, so each bit
    // appears on the line one edge after the decision that selects it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            signal   <= IDLE_LEVEL;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_bit  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    signal <= IDLE_LEVEL;
                    if (data_valid) begin
                        shreg    <= data;
                        par_bit  <= parity_of(8'(data), PARITY);
                        bit_cnt  <= '0;
                        stop_cnt <= 1'b0;
                        state    <= ST_START;
                        signal   <= ~IDLE_LEVEL;
                    end
                end

                ST_START: begin
                    if (bit_done) begin
                        state  <= ST_DATA;
                        signal <= shreg[0];
                    end
                end

                ST_DATA: begin
                    if (bit_done) begin
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + BW'(1);
                        if (bit_cnt == LAST_BIT) begin
                            if (PARITY != PARITY_NONE) begin
                                state  <= ST_PARITY_BIT;
                                signal <= par_bit;
                            end else begin
                                state  <= ST_STOP;
                                signal <= IDLE_LEVEL;
                            end
                        end else begin
                            signal <= shreg[1];
                        end
                    end
                end

                ST_PARITY_BIT: begin
                    if (bit_done) begin
                        state  <= ST_STOP;
                        signal <= IDLE_LEVEL;
                    end
                end

                ST_STOP: begin
                    if (bit_done) begin
                        if (stop_cnt == LAST_STOP) begin
                            state <= ST_IDLE;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                    signal <= IDLE_LEVEL;
                end

                default: begin
                    state  <= ST_IDLE;
                    signal <= IDLE_LEVEL;
                end
            endcase
        end
    end

    assign ready = (state == ST_IDLE);
    assign busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: several configurations side by side, each frame checked
// cycle by cycle against a bit-list model of the serial frame.
module tb_uart_tx;
    import uart_pkg::*;

    typedef struct {
        int   cpb;
        int   db;
        int   par;
        int   stops;
        logic il;
    } cfg_t;

    logic           clk = 1'b0;
    logic           reset;
    logic [7:0]     data_in [5];
    logic           valid   [5];
    logic           sig     [5];
    logic           rdy     [5];
    logic           bsy     [5];
    uart_tx_state_t st      [5];

    logic [0:0] exp_q[$];
    logic [0:0] act_sig_q[$];
    logic [0:0] act_busy_q[$];
    logic [0:0] act_rdy_q[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // 0: defaults, 1: even parity, 2: odd parity, 3: oversampled, 4: mixed
    uart_tx u0 (.clk(clk), .reset(reset), .data(data_in[0]), .data_valid(valid[0]),
                .ready(rdy[0]), .signal(sig[0]), .busy(bsy[0]), .state(st[0]));
    uart_tx #(.PARITY(1)) u1 (.clk(clk), .reset(reset), .data(data_in[1]), .data_valid(valid[1]),
                .ready(rdy[1]), .signal(sig[1]), .busy(bsy[1]), .state(st[1]));
    uart_tx #(.PARITY(2)) u2 (.clk(clk), .reset(reset), .data(data_in[2]), .data_valid(valid[2]),
                .ready(rdy[2]), .signal(sig[2]), .busy(bsy[2]), .state(st[2]));
    uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2), .IDLE_LEVEL(1'b1)) u3 (.clk(clk), .reset(reset),
                .data(data_in[3]), .data_valid(valid[3]),
                .ready(rdy[3]), .signal(sig[3]), .busy(bsy[3]), .state(st[3]));
    uart_tx #(.CLKS_PER_BIT(3), .DATA_BITS(5), .PARITY(2), .STOP_BITS(2)) u4 (.clk(clk), .reset(reset),
                .data(data_in[4][4:0]), .data_valid(valid[4]),
                .ready(rdy[4]), .signal(sig[4]), .busy(bsy[4]), .state(st[4]));

    function automatic cfg_t get_cfg(input int idx);
        cfg_t c;
        c = '{cpb: 1, db: 8, par: 0, stops: 1, il: 1'b0};
        case (idx)
            1: c.par = 1;
            2: c.par = 2;
            3: begin c.cpb = 4; c.stops = 2; c.il = 1'b1; end
            4: begin c.cpb = 3; c.db = 5; c.par = 2; c.stops = 2; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic int frame_cycles(input int idx);
        cfg_t c;
        c = get_cfg(idx);
        return (1 + c.db + ((c.par != 0) ? 1 : 0) + c.stops) * c.cpb;
    endfunction

    // Appends the expected per-clock line levels of one frame to exp_q.
    function automatic void model_frame(input int idx, input logic [7:0] word);
        cfg_t       c;
        logic [0:0] bits[$];
        int         ones;
        c    = get_cfg(idx);
        ones = 0;
        bits.push_back(~c.il);
        for (int i = 0; i < c.db; i++) begin
            bits.push_back(word[i]);
            ones += int'(word[i]);
        end
        if (c.par == 1) bits.push_back(1'(ones % 2));
        if (c.par == 2) bits.push_back(1'(1 - ones % 2));
        for (int i = 0; i < c.stops; i++) bits.push_back(c.il);
        foreach (bits[i]) begin
            for (int k = 0; k < c.cpb; k++) exp_q.push_back(bits[i]);
        end
    endfunction

    // Starts a frame from an idle DUT (called just after a falling edge) and
    // records n samples, one per falling edge after the handshake edge.
    task automatic capture(input int idx, input logic [7:0] word, input int n, input bit scramble);
        act_sig_q.delete();
        act_busy_q.delete();
        act_rdy_q.delete();
        data_in[idx] = word;
        valid[idx]   = 1'b1;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            act_sig_q.push_back(sig[idx]);
            act_busy_q.push_back(bsy[idx]);
            act_rdy_q.push_back(rdy[idx]);
            if (scramble && j < n - 2) begin
                data_in[idx] = 8'($urandom);
                valid[idx]   = 1'($urandom_range(0, 1));
            end else begin
                valid[idx] = 1'b0;
            end
        end
    endtask

    task automatic wait_idle(input int idx);
        int n;
        n = 0;
        while (!rdy[idx] && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!rdy[idx]) begin
            bad++;
            $display("FAIL wait_idle dut%0d: ready still %b after %0d cycles, need 1", idx, rdy[idx], n);
        end
    endtask

    task automatic test_reset();
        cfg_t c;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            c = get_cfg(i);
            total++;
            if (sig[i] !== c.il || rdy[i] !== 1'b1 || bsy[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset dut%0d: signal=%b ready=%b busy=%b, need %b 1 0",
                         i, sig[i], rdy[i], bsy[i], c.il);
            end
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_handshake_in_reset();
        reset        = 1'b1;
        valid[0]     = 1'b1;
        data_in[0]   = 8'h33;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            total++;
            if (sig[0] !== 1'b0 || bsy[0] !== 1'b0 || rdy[0] !== 1'b1) begin
                bad++;
                $display("FAIL hs_in_reset cycle %0d: signal=%b busy=%b ready=%b, need 0 0 1",
                         j, sig[0], bsy[0], rdy[0]);
            end
        end
        reset = 1'b0;
        capture(0, 8'h33, frame_cycles(0) + 1, 1'b0);
        exp_q.delete();
        model_frame(0, 8'h33);
        exp_q.push_back(1'b0);
        foreach (exp_q[j]) begin
            total++;
            if (act_sig_q[j] !== exp_q[j]) begin
                bad++;
                $display("FAIL hs_after_reset bit %0d: signal=%b need %b", j, act_sig_q[j], exp_q[j]);
            end
        end
    endtask

    task automatic test_basic();
        logic [9:0] lit;
        int         busy_n;
        lit = 10'b0101001011;  // bit i is the i-th line sample
        capture(0, 8'hA5, 12, 1'b0);
        exp_q.delete();
        model_frame(0, 8'hA5);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
        busy_n = 0;
        foreach (exp_q[j]) begin
            total++;
            if (act_sig_q[j] !== exp_q[j] || act_busy_q[j] !== 1'(j < 10)) begin
                bad++;
                $display("FAIL basic cycle %0d: signal=%b busy=%b need %b %b",
                         j, act_sig_q[j], act_busy_q[j], exp_q[j], 1'(j < 10));
            end
            if (act_busy_q[j] === 1'b1) busy_n++;
        end
        for (int j = 0; j < 10; j++) begin
            total++;
            if (act_sig_q[j] !== lit[j]) begin
                bad++;
                $display("FAIL basic_literal bit %0d: signal=%b need %b", j, act_sig_q[j], lit[j]);
            end
        end
        total++;
        if (busy_n != 10) begin
            bad++;
            $display("FAIL basic_busy_len: busy cycles=%0d need 10", busy_n);
        end
    endtask

    task automatic test_reset_mid_frame();
        exp_q.delete();
        model_frame(0, 8'h5A);
        data_in[0] = 8'h5A;
        valid[0]   = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            valid[0] = 1'b0;
            total++;
            if (sig[0] !== exp_q[j]) begin
                bad++;
                $display("FAIL midreset_pre bit %0d: signal=%b need %b", j, sig[0], exp_q[j]);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (sig[0] !== 1'b0 || rdy[0] !== 1'b1 || bsy[0] !== 1'b0) begin
            bad++;
            $display("FAIL midreset_abort: signal=%b ready=%b busy=%b need 0 1 0", sig[0], rdy[0], bsy[0]);
        end
        reset = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            total++;
            if (sig[0] !== 1'b0 || bsy[0] !== 1'b0) begin
                bad++;
                $display("FAIL midreset_quiet cycle %0d: signal=%b busy=%b need 0 0", j, sig[0], bsy[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [0:0] exp_rdy[$];
        int         pulses;
        exp_q.delete();
        model_frame(0, 8'h01);
        exp_q.push_back(1'b0);
        model_frame(0, 8'h80);
        exp_q.push_back(1'b0);
        for (int j = 0; j < 22; j++) exp_rdy.push_back(1'(j == 10 || j == 21));
        act_sig_q.delete();
        act_rdy_q.delete();
        data_in[0] = 8'h01;
        valid[0]   = 1'b1;
        for (int j = 0; j < 22; j++) begin
            @(negedge clk);
            act_sig_q.push_back(sig[0]);
            act_rdy_q.push_back(rdy[0]);
            data_in[0] = 8'h80;
            if (j == 11) valid[0] = 1'b0;
        end
        pulses = 0;
        foreach (exp_q[j]) begin
            total++;
            if (act_sig_q[j] !== exp_q[j] || act_rdy_q[j] !== exp_rdy[j]) begin
                bad++;
                $display("FAIL b2b cycle %0d: signal=%b ready=%b need %b %b",
                         j, act_sig_q[j], act_rdy_q[j], exp_q[j], exp_rdy[j]);
            end
            if (j < 21 && act_rdy_q[j] === 1'b1) pulses++;
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL b2b_ready_pulse: ready cycles between frames=%0d need 1", pulses);
        end
    endtask

    task automatic test_parity();
        logic [0:0] want_par;
        int         busy_n;
        for (int idx = 1; idx <= 2; idx++) begin
            want_par = (idx == 1) ? 1'b1 : 1'b0;
            capture(idx, 8'h07, 12, 1'b0);
            exp_q.delete();
            model_frame(idx, 8'h07);
            exp_q.push_back(1'b0);
            busy_n = 0;
            foreach (exp_q[j]) begin
                total++;
                if (act_sig_q[j] !== exp_q[j]) begin
                    bad++;
                    $display("FAIL parity%0d bit %0d: signal=%b need %b", idx, j, act_sig_q[j], exp_q[j]);
                end
                if (act_busy_q[j] === 1'b1) busy_n++;
            end
            total++;
            if (act_sig_q[9] !== want_par) begin
                bad++;
                $display("FAIL parity%0d_bit: parity=%b need %b", idx, act_sig_q[9], want_par);
            end
            total++;
            if (busy_n != 11) begin
                bad++;
                $display("FAIL parity%0d_len: busy cycles=%0d need 11", idx, busy_n);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_oversample();
        int busy_n;
        total++;
        if (sig[3] !== 1'b1) begin
            bad++;
            $display("FAIL os_idle: signal=%b need 1", sig[3]);
        end
        capture(3, 8'h00, 46, 1'b0);
        busy_n = 0;
        for (int j = 0; j < 46; j++) begin
            total++;
            if (act_sig_q[j] !== 1'(j >= 36)) begin
                bad++;
                $display("FAIL os cycle %0d: signal=%b need %b", j, act_sig_q[j], 1'(j >= 36));
            end
            if (act_busy_q[j] === 1'b1) busy_n++;
        end
        total++;
        if (busy_n != 44) begin
            bad++;
            $display("FAIL os_busy_len: busy cycles=%0d need 44", busy_n);
        end
    endtask

    task automatic test_random();
        int         idx;
        int         fc;
        logic [7:0] word;
        for (int it = 0; it < 24; it++) begin
            case ($urandom_range(0, 2))
                0:       idx = 0;
                1:       idx = 1;
                default: idx = 4;
            endcase
            fc   = frame_cycles(idx);
            word = 8'($urandom);
            exp_q.delete();
            model_frame(idx, word);
            exp_q.push_back(get_cfg(idx).il);
            capture(idx, word, fc + 1, 1'b1);
            foreach (exp_q[j]) begin
                total++;
                if (act_sig_q[j] !== exp_q[j] || act_busy_q[j] !== 1'(j < fc)) begin
                    bad++;
                    $display("FAIL random it%0d dut%0d word=%h cycle %0d: signal=%b busy=%b need %b %b",
                             it, idx, word, j, act_sig_q[j], act_busy_q[j], exp_q[j], 1'(j < fc));
                end
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in[i] = 8'h00;
            valid[i]   = 1'b0;
        end
        test_reset();
        test_handshake_in_reset();
        wait_idle(0);
        test_basic();
        test_reset_mid_frame();
        test_back_to_back();
        wait_idle(0);
        test_parity();
        test_oversample();
        wait_idle(3);
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
